// File: rtl/handshake_arbiter.sv
// handshake_arbiter: round-robin arbiter sharing one four-phase send/ack
// peripheral link among N_REQ requesters. The winner's request data goes to
// the peripheral, and the peripheral's response is returned to the winner
// before its grant is released.
// Optional feature macro: ARB_TIMEOUT_EN bounds each peripheral phase to
// TIMEOUT wait cycles and raises a sticky err_flag when that bound is hit.
module handshake_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_send,
  input  logic [N_REQ*DATA_W-1:0]   req_dados,
  output logic [N_REQ-1:0]          req_ack,
  output logic [DATA_W-1:0]         resp_dados,
  output logic                      per_send,
  output logic [DATA_W-1:0]         per_dados,
  input  logic                      per_ack,
  input  logic [DATA_W-1:0]         per_resp,
  output logic [$clog2(N_REQ)-1:0]  grant,
  output logic [2:0]                estado,
  output logic [7:0]                txn_count,
  output logic                      err_flag
);
  localparam int GW = $clog2(N_REQ);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    PER_REQ = 3'b001,
    PER_REL = 3'b010,
    REQ_REL = 3'b011
  } state_t;

  // Reject out-of-range configurations at elaboration.
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_chk
    $error("handshake_arbiter: parameter out of range");
  end

  state_t              state, nxt_state;
  logic [GW-1:0]       last_grant, nxt_last_grant, nxt_grant;
  logic [N_REQ-1:0]    nxt_req_ack;
  logic [DATA_W-1:0]   nxt_resp_dados, nxt_per_dados;
  logic                nxt_per_send;
  logic [7:0]          nxt_txn_count;

  logic [GW-1:0]       win, idx;
  logic                win_vld;
  logic [DATA_W-1:0]   win_data;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt, nxt_cnt;
  logic       err_q, nxt_err;
  assign err_flag = err_q;
`else
  assign err_flag = 1'b0;
`endif

  assign estado = state;

  // Round-robin search from last_grant+1; walking offsets downward lets the
  // nearest requester overwrite farther ones, so the first set bit wins.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    idx     = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      idx = GW'((int'(last_grant) + off) % N_REQ);
      if (req_send[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  // Mux out the winner's request data slice.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (win == GW'(i)) win_data = req_dados[i*DATA_W +: DATA_W];
  end

  // Next-state and next-output logic; everything holds unless a transition fires.
  always_comb begin
    nxt_state      = state;
    nxt_last_grant = last_grant;
    nxt_grant      = grant;
    nxt_req_ack    = req_ack;
    nxt_resp_dados = resp_dados;
    nxt_per_send   = per_send;
    nxt_per_dados  = per_dados;
    nxt_txn_count  = txn_count;
`ifdef ARB_TIMEOUT_EN
    nxt_cnt        = cnt;
    nxt_err        = err_q;
`endif
    case (state)
      IDLE: begin
        if (win_vld) begin
          nxt_grant      = win;
          nxt_last_grant = win;
          nxt_per_dados  = win_data;
          nxt_per_send   = 1'b1;
          nxt_state      = PER_REQ;
`ifdef ARB_TIMEOUT_EN
          nxt_cnt        = '0;
`endif
        end
      end
      PER_REQ: begin
        if (per_ack) begin
          nxt_resp_dados = per_resp;
          nxt_per_send   = 1'b0;
          nxt_state      = PER_REL;
`ifdef ARB_TIMEOUT_EN
          nxt_cnt        = '0;
        end else if (cnt == TO_LAST) begin
          nxt_per_send       = 1'b0;
          nxt_resp_dados     = '0;
          nxt_err            = 1'b1;
          nxt_req_ack[grant] = 1'b1;
          nxt_state          = REQ_REL;
        end else begin
          nxt_cnt = cnt + 8'd1;
`endif
        end
      end
      PER_REL: begin
        if (!per_ack) begin
          nxt_req_ack[grant] = 1'b1;
          nxt_txn_count      = txn_count + 8'd1;
          nxt_state          = REQ_REL;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt == TO_LAST) begin
          nxt_per_send       = 1'b0;
          nxt_resp_dados     = '0;
          nxt_err            = 1'b1;
          nxt_req_ack[grant] = 1'b1;
          nxt_state          = REQ_REL;
        end else begin
          nxt_cnt = cnt + 8'd1;
`endif
        end
      end
      REQ_REL: begin
        if (!req_send[grant]) begin
          nxt_req_ack[grant] = 1'b0;
          nxt_state          = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // State and output registers; reset drops the link immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GW'(N_REQ - 1);
      grant      <= '0;
      req_ack    <= '0;
      resp_dados <= '0;
      per_send   <= 1'b0;
      per_dados  <= '0;
      txn_count  <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt        <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state      <= nxt_state;
      last_grant <= nxt_last_grant;
      grant      <= nxt_grant;
      req_ack    <= nxt_req_ack;
      resp_dados <= nxt_resp_dados;
      per_send   <= nxt_per_send;
      per_dados  <= nxt_per_dados;
      txn_count  <= nxt_txn_count;
`ifdef ARB_TIMEOUT_EN
      cnt        <= nxt_cnt;
      err_q      <= nxt_err;
`endif
    end
  end
endmodule

// File: tb/tb_handshake_arbiter.sv
// Bench for handshake_arbiter (N_REQ=4, DATA_W=4): per-cycle vector table for
// the basic transaction and protocol corners, then hand-written sequences for
// round-robin order, mid-transaction reset, counter wrap and (with
// ARB_TIMEOUT_EN) the phase timeout.
module tb_handshake_arbiter;
  logic        clk, rst;
  logic [3:0]  req_send;
  logic [15:0] req_dados;
  logic [3:0]  req_ack;
  logic [3:0]  resp_dados;
  logic        per_send;
  logic [3:0]  per_dados;
  logic        per_ack;
  logic [3:0]  per_resp;
  logic [1:0]  grant;
  logic [2:0]  estado;
  logic [7:0]  txn_count;
  logic        err_flag;

  int checks = 0;
  int failures = 0;

  handshake_arbiter #(.N_REQ(4), .DATA_W(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req_send(req_send), .req_dados(req_dados),
    .req_ack(req_ack), .resp_dados(resp_dados), .per_send(per_send),
    .per_dados(per_dados), .per_ack(per_ack), .per_resp(per_resp),
    .grant(grant), .estado(estado), .txn_count(txn_count), .err_flag(err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rs;
    logic [15:0] rd;
    logic        pa;
    logic [3:0]  pr;
    logic [2:0]  e_st;
    logic        e_ps;
    logic [3:0]  e_ack;
    logic [3:0]  e_pd;
    logic [3:0]  e_rsp;
    logic [1:0]  e_gr;
    logic [7:0]  e_txn;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] slice(input int g);
    return req_dados[g*4 +: 4];
  endfunction

  task automatic do_reset();
    req_send = '0; per_ack = 1'b0; per_resp = '0;
    rst = 1'b1;
    #2;
    chk("rst_estado", estado, 0);
    chk("rst_req_ack", req_ack, 0);
    step();
    rst = 1'b0;
  endtask

  // One full transaction for requester g with a zero-wait peripheral model.
  task automatic txn(input int g, input logic [3:0] resp, input bit reassert);
    int n;
    n = 0;
    while (!per_send && n < 20) begin step(); n++; end
    chk("per_send_up", per_send, 1);
    chk("grant", grant, g);
    chk("per_dados", per_dados, slice(g));
    per_ack = 1'b1; per_resp = resp;
    n = 0;
    while (per_send && n < 20) begin step(); n++; end
    chk("estado_per_rel", estado, 3'b010);
    per_ack = 1'b0; per_resp = '0;
    n = 0;
    while (req_ack == 4'b0 && n < 20) begin step(); n++; end
    chk("req_ack_onehot", req_ack, 4'b1 << g);
    chk("resp_dados", resp_dados, resp);
    req_send[g] = 1'b0;
    step();
    chk("req_ack_clear", req_ack, 0);
    chk("estado_idle", estado, 0);
    if (reassert) req_send[g] = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rs     rd        pa  pr    st  ps ack  pd  rsp gr txn
    vecs[0]  = '{4'h0, 16'h0003, 0, 4'h0, 3'd0, 0, 4'h0, 4'h0, 4'h0, 2'd0, 8'd0};
    vecs[1]  = '{4'h1, 16'h0003, 0, 4'h0, 3'd1, 1, 4'h0, 4'h3, 4'h0, 2'd0, 8'd0};
    vecs[2]  = '{4'h1, 16'h0003, 1, 4'h4, 3'd2, 0, 4'h0, 4'h3, 4'h4, 2'd0, 8'd0};
    vecs[3]  = '{4'h1, 16'h0003, 0, 4'h0, 3'd3, 0, 4'h1, 4'h3, 4'h4, 2'd0, 8'd1};
    vecs[4]  = '{4'h0, 16'h0003, 0, 4'h0, 3'd0, 0, 4'h0, 4'h3, 4'h4, 2'd0, 8'd1};
    vecs[5]  = '{4'h0, 16'h0003, 0, 4'h0, 3'd0, 0, 4'h0, 4'h3, 4'h4, 2'd0, 8'd1};
    vecs[6]  = '{4'h2, 16'h00A0, 0, 4'h0, 3'd1, 1, 4'h0, 4'hA, 4'h4, 2'd1, 8'd1};
    vecs[7]  = '{4'h2, 16'h00A0, 0, 4'h0, 3'd1, 1, 4'h0, 4'hA, 4'h4, 2'd1, 8'd1};
    vecs[8]  = '{4'h0, 16'h00A0, 1, 4'h7, 3'd2, 0, 4'h0, 4'hA, 4'h7, 2'd1, 8'd1};
    vecs[9]  = '{4'h0, 16'h00A0, 1, 4'h5, 3'd2, 0, 4'h0, 4'hA, 4'h7, 2'd1, 8'd1};
    vecs[10] = '{4'h0, 16'h00A0, 0, 4'h0, 3'd3, 0, 4'h2, 4'hA, 4'h7, 2'd1, 8'd2};
    vecs[11] = '{4'h0, 16'h00A0, 0, 4'h0, 3'd0, 0, 4'h0, 4'hA, 4'h7, 2'd1, 8'd2};

    req_send = '0; req_dados = '0; per_ack = 1'b0; per_resp = '0;
    rst = 1'b1;
    #3;
    chk("reset_estado", estado, 0);
    chk("reset_per_send", per_send, 0);
    chk("reset_req_ack", req_ack, 0);
    chk("reset_per_dados", per_dados, 0);
    chk("reset_resp", resp_dados, 0);
    chk("reset_grant", grant, 0);
    chk("reset_txn", txn_count, 0);
    chk("reset_err", err_flag, 0);
    step();
    rst = 1'b0;

    // Table: single transaction, wait states, and a requester dropping early.
    for (int i = 0; i < 12; i++) begin
      req_send = vecs[i].rs; req_dados = vecs[i].rd;
      per_ack = vecs[i].pa; per_resp = vecs[i].pr;
      step();
      chk($sformatf("v%0d_estado", i), estado, vecs[i].e_st);
      chk($sformatf("v%0d_per_send", i), per_send, vecs[i].e_ps);
      chk($sformatf("v%0d_req_ack", i), req_ack, vecs[i].e_ack);
      chk($sformatf("v%0d_per_dados", i), per_dados, vecs[i].e_pd);
      chk($sformatf("v%0d_resp", i), resp_dados, vecs[i].e_rsp);
      chk($sformatf("v%0d_grant", i), grant, vecs[i].e_gr);
      chk($sformatf("v%0d_txn", i), txn_count, vecs[i].e_txn);
    end
    chk("err_flag_default", err_flag, 0);

    // All four request together and re-request: grants 0,1,2,3,0.
    do_reset();
    req_dados = 16'hDCBA;
    req_send = 4'hF;
    txn(0, 4'h5, 1);
    txn(1, 4'h6, 1);
    txn(2, 4'h7, 1);
    txn(3, 4'h8, 1);
    txn(0, 4'h9, 0);
    req_send = '0;
    chk("rr_txn_count", txn_count, 5);

    // Late arrivals: 2 then 1 during requester 0's transaction -> 1 then 2.
    do_reset();
    req_send = 4'b0001;
    step();
    chk("late_grant0", grant, 0);
    req_send[2] = 1'b1;
    step();
    req_send[1] = 1'b1;
    txn(0, 4'h1, 0);
    txn(1, 4'h2, 0);
    txn(2, 4'h3, 0);

    // Reset while in PER_REL, then priority restarts at requester 0.
    do_reset();
    req_send = 4'b0010;
    step();
    chk("mid_grant1", grant, 1);
    per_ack = 1'b1; per_resp = 4'hE;
    step();
    chk("mid_per_rel", estado, 3'b010);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_estado", estado, 0);
    chk("mid_rst_per_send", per_send, 0);
    chk("mid_rst_req_ack", req_ack, 0);
    chk("mid_rst_resp", resp_dados, 0);
    per_ack = 1'b0; req_send = 4'b0101;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_grant", grant, 0);
    chk("post_rst_per_send", per_send, 1);
    txn(0, 4'h4, 0);
    txn(2, 4'h5, 0);
    req_send = '0;

    // 256 transactions wrap txn_count back to 0.
    do_reset();
    for (int k = 0; k < 256; k++) begin
      req_send[0] = 1'b1;
      txn(0, 4'(k), 0);
      if (k == 254) chk("wrap_255", txn_count, 255);
    end
    chk("wrap_0", txn_count, 0);

`ifdef ARB_TIMEOUT_EN
    // Peripheral never acks: per_send falls after 15 wait cycles.
    do_reset();
    req_send = 4'b0001;
    txn(0, 4'h9, 1);
    step();
    chk("to_per_send_up", per_send, 1);
    for (int k = 0; k < 14; k++) step();
    chk("to_still_waiting", per_send, 1);
    step();
    chk("to_per_send_down", per_send, 0);
    chk("to_err", err_flag, 1);
    chk("to_resp", resp_dados, 0);
    chk("to_req_ack", req_ack, 4'b0001);
    chk("to_estado", estado, 3'b011);
    chk("to_txn", txn_count, 1);
    req_send = '0;
    step();
    chk("to_err_sticky", err_flag, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/handshake_arbiter.md
# handshake_arbiter

Round-robin arbiter that shares one four-phase send/ack peripheral link among N_REQ CPU-side requesters. Each requester runs its own four-phase handshake with the arbiter. The arbiter grants one requester at a time, drives the full peripheral handshake on that requester's behalf, and returns the peripheral's response data before releasing the grant. It sits between the CPU state machines and the single peripheral state machine.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 4, width of request and response data
- TIMEOUT, 15, cycles allowed per peripheral phase (used only with ARB_TIMEOUT_EN; 1..255)

- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, asynchronous, active-high
- req_send  in  N_REQ  per-requester send; bit i held high while requester i waits
- req_dados  in  N_REQ*DATA_W  request data; slice i is bits [i*DATA_W +: DATA_W], stable while req_send[i]=1
- req_ack  out  N_REQ  per-requester ack; one-hot or zero
- resp_dados  out  DATA_W  peripheral response for the granted requester; valid while its req_ack bit is 1
- per_send  out  1  send toward the peripheral
- per_dados  out  DATA_W  data toward the peripheral
- per_ack  in  1  ack from the peripheral
- per_resp  in  DATA_W  peripheral response data, sampled on the cycle per_ack=1 is first seen
- grant  out  clog2(N_REQ)  index of the current or most recent grant
- estado  out  3  current FSM state encoding
- txn_count  out  8  completed transactions, wraps from 255 to 0
- err_flag  out  1  sticky timeout error

## Operation
- All inputs are synchronous to clk. All outputs are registered.
- States (estado): IDLE=000, PER_REQ=001, PER_REL=010, REQ_REL=011.
- IDLE: if any req_send bit is 1, choose the winner by round-robin. The search starts at last_grant+1 (mod N_REQ); the first set bit wins. Then:
  - grant <= winner, last_grant <= winner
  - per_dados <= slice of winner, per_send <= 1
  - go to PER_REQ
  - With no request, stay in IDLE; all outputs hold.
- PER_REQ: wait for per_ack=1. Then resp_dados <= per_resp, per_send <= 0, go to PER_REL.
- PER_REL: wait for per_ack=0. Then req_ack[grant] <= 1, txn_count <= txn_count+1 (mod 256), go to REQ_REL.
- REQ_REL: wait for req_send[grant]=0. Then req_ack[grant] <= 0, go to IDLE.
- Requests from other requesters that arrive during a transaction stay pending. They are served in round-robin order afterwards.
- Simultaneous requests: the lowest index at or after last_grant+1 wins. No requester waits more than N_REQ-1 transactions.
- If a requester drops req_send before its ack (protocol violation), the transaction still completes. REQ_REL then exits on the first cycle it is evaluated.
- per_dados holds its value from grant until the next grant.

## Timing
- Reset values: state IDLE, req_ack=0, resp_dados=0, per_send=0, per_dados=0, grant=0, last_grant=N_REQ-1 (so requester 0 has top priority first), txn_count=0, err_flag=0.
- Asserting rst mid-transaction clears everything immediately and asynchronously. per_send and req_ack drop with no completion.
- Request sampled at edge k → per_send=1 after edge k.
- per_ack=1 seen at edge m → per_send=0 after edge m.
- per_ack=0 seen at edge p → req_ack=1 after edge p.
- req_send=0 seen at edge q → req_ack=0 after edge q. A new grant can occur at edge q+1.
- Minimum transaction is 4 cycles, given zero-wait responders.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit phase counter clears on entry to PER_REQ and PER_REL and increments on each cycle spent waiting in those states.
  - When the count reaches TIMEOUT without the awaited per_ack level: per_send <= 0, resp_dados <= 0, err_flag <= 1, req_ack[grant] <= 1, go to REQ_REL.
  - txn_count is not incremented on a timeout.
  - err_flag clears only on rst.
- ARB_TIMEOUT_EN undefined: no counter is present, the FSM waits indefinitely, err_flag is constant 0, and TIMEOUT is ignored.

## Test plan
- Reset then a single request: req_send=0001, slice0=0x3, the peripheral acks one cycle later with per_resp=0x4 → per_dados=0x3, resp_dados=0x4, req_ack=0001, txn_count=1, estado sequence 000→001→010→011→000.
- All four requesters assert together and hold → grants 0,1,2,3,0 in order; req_ack is always one-hot; txn_count=5 after five transactions.
- Requester 2 asserts during requester 0's transaction, requester 1 asserts later → the next grants are 1 then 2, since last_grant=0 and the search starts at 1.
- rst pulsed while in PER_REL → per_send=0, req_ack=0, estado=000 immediately; the next request starts with grant 0 priority.
- With ARB_TIMEOUT_EN and TIMEOUT=15, the peripheral never acks → per_send falls after 15 wait cycles, err_flag=1, resp_dados=0, req_ack set, txn_count unchanged.
- 256 back-to-back transactions → txn_count wraps to 0.
